// File: rtl/adc_pwm_array.sv
// Purpose: NCH single-slope ADC channels sharing one ramp sequencer, each result driving a PWM output.
// Latency: results appear on the CAPTURE cycle after the last channel trips; PWM duty follows at the next period boundary.
// Backpressure: none; sample_valid is a one-cycle strobe that cannot be stalled, and result holds until the next conversion.
module adc_pwm_array #(
  parameter int NCH              = 4,
  parameter int N                = 8,
  parameter int PRESCALE         = 39,
  parameter int DISCHARGE_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [NCH-1:0]   compared_value,
  output logic [NCH-1:0]   discharge,
  output logic [NCH-1:0]   pwm,
  output logic [NCH*N-1:0] result,
  output logic [NCH-1:0]   overflow,
  output logic             sample_valid
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
  localparam logic [N-1:0]  CNT_MAX    = '1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DIS_LAST   = DW'(DISCHARGE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DISCHARGE, RAMP, CAPTURE} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   dis_cnt;
  logic [PW-1:0]   presc;
  logic [N-1:0]    ramp_cnt;
  logic [NCH-1:0]  tripped, ovf_pend;
  logic [NCH-1:0]  trip_now, ovf_now;
  logic [N-1:0]    cap [NCH];
  logic [N-1:0]    pwm_cnt;
  logic [N-1:0]    duty [NCH];
  logic            tick, conv_done;

  assign tick      = (state == RAMP) && (presc == PRESC_LAST);
  assign conv_done = tick && (&(tripped | trip_now));

  // Per-tick trip decision: comparator hit, or forced saturation at the top of the ramp.
  always_comb begin
    trip_now = '0;
    ovf_now  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (tick && !tripped[i]) begin
        if (compared_value[i]) begin
          trip_now[i] = 1'b1;
        end else if (ramp_cnt == CNT_MAX) begin
          trip_now[i] = 1'b1;
          ovf_now[i]  = 1'b1;
        end
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Sequencer next state; enable is only consulted in IDLE and CAPTURE so a conversion always completes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (enable) state_nxt = DISCHARGE;
      DISCHARGE: if (dis_cnt == DIS_LAST) state_nxt = RAMP;
      RAMP:      if (conv_done) state_nxt = CAPTURE;
      CAPTURE:   state_nxt = enable ? DISCHARGE : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Discharge timer, prescaler, saturating ramp count and per-channel trip/overflow flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dis_cnt  <= '0;
      presc    <= '0;
      ramp_cnt <= '0;
      tripped  <= '0;
      ovf_pend <= '0;
    end else begin
      dis_cnt <= (state == DISCHARGE && state_nxt == DISCHARGE) ? dis_cnt + 1'b1 : '0;
      if (state == RAMP) begin
        presc    <= tick ? '0 : presc + 1'b1;
        tripped  <= tripped | trip_now;
        ovf_pend <= ovf_pend | ovf_now;
        if (tick && ramp_cnt != CNT_MAX) ramp_cnt <= ramp_cnt + 1'b1;
      end else begin
        presc    <= '0;
        ramp_cnt <= '0;
        tripped  <= '0;
        ovf_pend <= '0;
      end
    end
  end

  // Capture registers plus the published result, loaded together on the edge that enters CAPTURE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) cap[i] <= '0;
      result   <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (trip_now[i]) cap[i] <= ramp_cnt;
      end
      if (conv_done) begin
        for (int i = 0; i < NCH; i++) begin
          result[i*N +: N] <= trip_now[i] ? ramp_cnt : cap[i];
        end
        overflow <= ovf_pend | ovf_now;
      end
    end
  end

  // Free-running PWM counter; duty shadows reload only in the last cycle of each period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= '0;
      for (int i = 0; i < NCH; i++) duty[i] <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == CNT_MAX) begin
        for (int i = 0; i < NCH; i++) duty[i] <= result[i*N +: N];
      end
    end
  end

  // Output decode: channels discharge outside RAMP and from the cycle after they trip.
  always_comb begin
    discharge    = (state == RAMP) ? tripped : '1;
    sample_valid = (state == CAPTURE);
    for (int i = 0; i < NCH; i++) pwm[i] = (pwm_cnt < duty[i]);
  end

endmodule

// File: doc/adc_pwm_array.md
ADC_PWM_ARRAY -- requirements
Module: adc_pwm_array

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of parallel single-slope ADC channels.
REQ-002 SHALL have parameter N, default 8, meaning conversion and PWM resolution in bits.
REQ-003 SHALL have parameter PRESCALE, default 39, meaning clk cycles per ramp-counter tick (>=1).
REQ-004 SHALL have parameter DISCHARGE_CYCLES, default 10, meaning clk cycles of capacitor discharge before each ramp (>=1).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge and there are no derived clocks.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, continuous-conversion enable, sampled at clk.
REQ-008 SHALL have port compared_value, input, NCH, per-channel comparator output (1 = capacitor has reached the input level).
REQ-009 SHALL have port discharge, output, NCH, per-channel capacitor discharge switch (1 = discharging).
REQ-010 SHALL have port pwm, output, NCH, per-channel PWM output.
REQ-011 SHALL have port result, output, NCH*N, latest conversion result; channel i occupies bits [i*N +: N].
REQ-012 SHALL have port overflow, output, NCH, per-channel flag: the last conversion saturated.
REQ-013 SHALL have port sample_valid, output, 1, one-cycle strobe marking new result/overflow values.

Function
REQ-014 SHALL implement states IDLE, DISCHARGE, RAMP and CAPTURE in a single shared sequencer.
REQ-015 IDLE SHALL drive all discharge bits to 1 and SHALL go to DISCHARGE when enable=1.
REQ-016 DISCHARGE SHALL drive all discharge bits to 1 for exactly DISCHARGE_CYCLES cycles, then go to RAMP with ramp count, prescaler and per-channel tripped flags cleared.
REQ-017 RAMP SHALL advance the prescaler every clk and SHALL generate one tick every PRESCALE cycles, the first tick PRESCALE cycles after RAMP entry.
REQ-018 On each tick, every untripped channel with compared_value=1 SHALL capture the current ramp count and set its tripped flag.
REQ-019 On each tick, every untripped channel with compared_value=0 and ramp count = 2^N-1 SHALL capture 2^N-1, set its tripped flag and set its pending overflow.
REQ-020 The shared N-bit ramp count SHALL increment once per tick and SHALL never wrap.
REQ-021 In RAMP, discharge[i] SHALL be 0 while channel i is untripped and 1 from the cycle after it trips.
REQ-022 RAMP SHALL go to CAPTURE on the edge after the tick on which the last channel trips.
REQ-023 On entry to CAPTURE, result and overflow SHALL load all captured values and pending overflows simultaneously.
REQ-024 sample_valid SHALL be 1 exactly during the single CAPTURE cycle and 0 otherwise.
REQ-025 CAPTURE SHALL go to DISCHARGE if enable=1, else to IDLE.
REQ-026 Deasserting enable outside IDLE SHALL NOT abort a conversion; the current conversion SHALL complete with one sample_valid strobe.
REQ-027 A shared N-bit PWM counter SHALL increment every clk and wrap from 2^N-1 to 0.
REQ-028 Each channel SHALL hold a duty shadow register that loads from result only on the cycle where the PWM counter is 2^N-1, so the duty changes only at the period boundary.
REQ-029 pwm[i] SHALL be 1 iff the PWM counter < duty[i]; duty 0 gives constant 0, and duty 2^N-1 gives 1 for 2^N-1 of 2^N cycles.

Reset
REQ-030 reset=0 SHALL immediately force the following, regardless of state including mid-RAMP: state IDLE, discharge all 1, result 0, overflow 0, sample_valid 0, duty 0, pwm 0, and all counters and flags 0.
REQ-031 After reset deasserts, the first conversion SHALL start only through IDLE -> DISCHARGE.

Verification (NCH=4, N=8, PRESCALE=4, DISCHARGE_CYCLES=10)
REQ-032 Check nominal capture: reset, then enable=1, with ch0 comparator rising before the tick at ramp count 100 and others before count 50/150/200. Required: result = 100/50/150/200, overflow=0, sample_valid once, and discharge[0] rising the cycle after its trip.
REQ-033 Check saturation: ch2 comparator held 0. Required: result ch2=255, overflow[2]=1, CAPTURE reached after 256 ticks (1024 RAMP cycles).
REQ-034 Check immediate trip: ch1 comparator held 1 from RAMP entry. Required: result ch1=0 and overflow[1]=0.
REQ-035 Check PWM shadowing: result ch3 changes from 200 to 64 mid-period. Required: the current period stays at 200 high cycles, and the next period gives exactly 64 high cycles out of 256.
REQ-036 Check enable drop: enable -> 0 during RAMP. Required: the conversion finishes, sample_valid pulses once, then IDLE with discharge=4'b1111 and no further strobes.
REQ-037 Check asynchronous reset: reset=0 mid-RAMP, asserted between clk edges. Required: all outputs reach the REQ-030 values without waiting for a clk edge, and after release a full DISCHARGE of 10 cycles precedes the next RAMP.
